// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: PC request side, byte-wide instruction memory
// side and the decode handshake, as one interface with two views.
interface instr_fetch_unit_if;
    logic [15:0] pc_addr;
    logic        fetch_req;
    logic        flush;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_wre;
    logic        misalign_err;
    logic        timeout_err;

    modport slave (
        input  pc_addr,
        input  fetch_req,
        input  flush,
        input  mem_rdata,
        input  mem_ready,
        input  instr_ready,
        output mem_addr,
        output mem_rd,
        output instr,
        output instr_valid,
        output pc_wre,
        output misalign_err,
        output timeout_err
    );

    modport master (
        output pc_addr,
        output fetch_req,
        output flush,
        output mem_rdata,
        output mem_ready,
        output instr_ready,
        input  mem_addr,
        input  mem_rd,
        input  instr,
        input  instr_valid,
        input  pc_wre,
        input  misalign_err,
        input  timeout_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Two-read instruction fetch from byte-wide memory with a decode
// handshake and a one-cycle PC write-enable after acceptance.
module instr_fetch_unit #(
    parameter int TIMEOUT       = 64,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    instr_fetch_unit_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_LO = 3'd1;
    localparam logic [2:0] S_RD_HI = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_addr;
    logic        r_rd;
    logic [7:0]  r_lo;
    logic [15:0] r_instr;
    logic        r_valid;
    logic        r_wre;
    logic        r_mis;
    logic        r_to;
    logic [7:0]  r_wait;

    logic        w_tmo;
    logic [15:0] w_word;

    assign w_tmo = !bus.mem_ready && (r_wait == LP_LAST);

    // r_lo holds the even-address byte; its placement depends on order
    assign w_word = LITTLE_ENDIAN ? {bus.mem_rdata, r_lo}
                                  : {r_lo, bus.mem_rdata};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_addr  <= 16'h0000;
            r_rd    <= 1'b0;
            r_lo    <= 8'h00;
            r_instr <= 16'h0000;
            r_valid <= 1'b0;
            r_wre   <= 1'b0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
            r_wait  <= 8'h00;
        end else begin
            r_wre <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_rd    <= 1'b0;
                r_valid <= 1'b0;
                r_mis   <= 1'b0;
                r_to    <= 1'b0;
                r_wait  <= 8'h00;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        if (bus.fetch_req) begin
                            if (bus.pc_addr[0]) begin
                                r_state <= S_ERR;
                                r_mis   <= 1'b1;
                            end else begin
                                r_state <= S_RD_LO;
                                r_addr  <= bus.pc_addr;
                                r_rd    <= 1'b1;
                                r_wait  <= 8'h00;
                            end
                        end
                    end
                    S_RD_LO: begin
                        if (bus.mem_ready) begin
                            r_lo    <= bus.mem_rdata;
                            r_addr  <= {r_addr[15:1], 1'b1};
                            r_state <= S_RD_HI;
                            r_wait  <= 8'h00;
                        end else if (w_tmo) begin
                            r_rd    <= 1'b0;
                            r_to    <= 1'b1;
                            r_state <= S_ERR;
                            r_wait  <= 8'h00;
                        end else begin
                            r_wait  <= r_wait + 8'h01;
                        end
                    end
                    S_RD_HI: begin
                        if (bus.mem_ready) begin
                            r_instr <= w_word;
                            r_rd    <= 1'b0;
                            r_valid <= 1'b1;
                            r_state <= S_HOLD;
                            r_wait  <= 8'h00;
                        end else if (w_tmo) begin
                            r_rd    <= 1'b0;
                            r_to    <= 1'b1;
                            r_state <= S_ERR;
                            r_wait  <= 8'h00;
                        end else begin
                            r_wait  <= r_wait + 8'h01;
                        end
                    end
                    S_HOLD: begin
                        if (bus.instr_ready) begin
                            r_valid <= 1'b0;
                            r_wre   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_ERR: begin
                        r_rd <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_rd    <= 1'b0;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr     = r_addr;
    assign bus.mem_rd       = r_rd;
    assign bus.instr        = r_instr;
    assign bus.instr_valid  = r_valid;
    assign bus.pc_wre       = r_wre;
    assign bus.misalign_err = r_mis;
    assign bus.timeout_err  = r_to;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (both byte orders,
// two timeouts) checked every cycle against a bench-side fetch model.
module tb_instr_fetch_unit;

    localparam int TO0 = 64;
    localparam int TO1 = 4;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [15:0] pc_addr = 16'h0000;
    logic        fetch_req = 1'b0;
    logic        flush = 1'b0;
    logic        instr_ready = 1'b0;
    int          waits = 0;
    logic        en = 1'b1;
    logic        frdy = 1'b0;
    logic [7:0]  mem [256];
    int          vecs = 0;
    int          bad = 0;
    int          n;

    always #5 CLK = ~CLK;

    instr_fetch_unit_if bus0 ();
    instr_fetch_unit_if bus1 ();

    instr_fetch_unit #(.TIMEOUT(TO0), .LITTLE_ENDIAN(1'b1)) u0 (
        .CLK(CLK), .RESET(RESET), .bus(bus0));
    instr_fetch_unit #(.TIMEOUT(TO1), .LITTLE_ENDIAN(1'b0)) u1 (
        .CLK(CLK), .RESET(RESET), .bus(bus1));

    // model state: phase 0 idle, 1 first byte, 2 second byte, 3 offered, 4 error
    int          m_ph  [2];
    logic [15:0] m_addr[2];
    logic [15:0] m_ins [2];
    logic [7:0]  m_lo  [2];
    logic        m_rd  [2];
    logic        m_val [2];
    logic        m_wre [2];
    logic        m_mis [2];
    logic        m_to  [2];
    int          m_wt  [2];
    int          rc    [2];
    logic        rdy   [2];
    logic [7:0]  rdat  [2];
    logic [36:0] m_out [2];
    logic [36:0] d_out [2];

    function automatic int tov(input int k);
        return (k == 0) ? TO0 : TO1;
    endfunction

    function automatic logic [15:0] join16(input int k, input logic [7:0] ev,
                                           input logic [7:0] od);
        return (k == 0) ? {od, ev} : {ev, od};
    endfunction

    // memory answers the model's read strobe after `waits` stall cycles
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rdy[k]   = frdy || (en && m_rd[k] && (rc[k] == waits));
            rdat[k]  = rdy[k] ? mem[m_addr[k][7:0]] : 8'hEE;
            m_out[k] = {m_addr[k], m_rd[k], m_ins[k], m_val[k],
                        m_wre[k], m_mis[k], m_to[k]};
        end
    end

    assign bus0.pc_addr     = pc_addr;
    assign bus0.fetch_req   = fetch_req;
    assign bus0.flush       = flush;
    assign bus0.instr_ready = instr_ready;
    assign bus0.mem_ready   = rdy[0];
    assign bus0.mem_rdata   = rdat[0];
    assign bus1.pc_addr     = pc_addr;
    assign bus1.fetch_req   = fetch_req;
    assign bus1.flush       = flush;
    assign bus1.instr_ready = instr_ready;
    assign bus1.mem_ready   = rdy[1];
    assign bus1.mem_rdata   = rdat[1];

    assign d_out[0] = {bus0.mem_addr, bus0.mem_rd, bus0.instr, bus0.instr_valid,
                       bus0.pc_wre, bus0.misalign_err, bus0.timeout_err};
    assign d_out[1] = {bus1.mem_addr, bus1.mem_rd, bus1.instr, bus1.instr_valid,
                       bus1.pc_wre, bus1.misalign_err, bus1.timeout_err};

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < 2; k++) begin
                rc[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                rc[k] <= (m_rd[k] && !rdy[k]) ? rc[k] + 1 : 0;
            end
        end
    end

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] <= 0;   m_addr[k] <= '0; m_ins[k] <= '0;
                m_lo[k] <= '0;  m_rd[k] <= 1'b0; m_val[k] <= 1'b0;
                m_wre[k] <= 1'b0; m_mis[k] <= 1'b0; m_to[k] <= 1'b0;
                m_wt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_wre[k] <= 1'b0;
                if (flush) begin
                    m_ph[k] <= 0; m_rd[k] <= 1'b0; m_val[k] <= 1'b0;
                    m_mis[k] <= 1'b0; m_to[k] <= 1'b0; m_wt[k] <= 0;
                end else if (m_ph[k] == 0 && fetch_req) begin
                    if (pc_addr[0]) begin
                        m_ph[k] <= 4; m_mis[k] <= 1'b1;
                    end else begin
                        m_ph[k] <= 1; m_addr[k] <= pc_addr;
                        m_rd[k] <= 1'b1; m_wt[k] <= 0;
                    end
                end else if (m_ph[k] == 1 || m_ph[k] == 2) begin
                    if (rdy[k]) begin
                        m_wt[k] <= 0;
                        if (m_ph[k] == 1) begin
                            m_lo[k] <= rdat[k];
                            m_addr[k] <= m_addr[k] + 16'd1;
                            m_ph[k] <= 2;
                        end else begin
                            m_ins[k] <= join16(k, m_lo[k], rdat[k]);
                            m_rd[k] <= 1'b0; m_val[k] <= 1'b1; m_ph[k] <= 3;
                        end
                    end else if (m_wt[k] + 1 >= tov(k)) begin
                        m_rd[k] <= 1'b0; m_to[k] <= 1'b1;
                        m_ph[k] <= 4; m_wt[k] <= 0;
                    end else begin
                        m_wt[k] <= m_wt[k] + 1;
                    end
                end else if (m_ph[k] == 3 && instr_ready) begin
                    m_val[k] <= 1'b0; m_wre[k] <= 1'b1; m_ph[k] <= 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [36:0] act,
                       input logic [36:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        chk("cycle_u0", d_out[0], m_out[0]);
        chk("cycle_u1", d_out[1], m_out[1]);
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus0.instr_valid && cnt < 40);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[16] = 8'h34; mem[17] = 8'h12;
        mem[0]  = 8'hCD; mem[1]  = 8'hAB;

        step(); step();
        chk("rst_u0", d_out[0], 37'h0);
        chk("rst_u1", d_out[1], 37'h0);
        RESET = 1'b1;
        step();

        waits = 0; instr_ready = 1'b1;
        pc_addr = 16'h0010; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        chk("t1_addr_lo", {bus0.mem_addr, bus0.mem_rd}, {16'h0010, 1'b1});
        step();
        chk("t1_addr_hi", {bus0.mem_addr, bus0.mem_rd, bus0.instr_valid},
            {16'h0011, 1'b1, 1'b0});
        step();
        chk("t1_valid", {bus0.instr_valid, bus1.instr_valid}, 2'b11);
        chk("t1_instr_le", bus0.instr, 16'h1234);
        chk("t1_instr_be", bus1.instr, 16'h3412);
        step();
        chk("t1_wre", {bus0.pc_wre, bus0.instr_valid}, 2'b10);
        step();
        chk("t1_wre_end", {bus0.pc_wre, bus1.pc_wre}, 2'b00);

        waits = 3;
        pc_addr = 16'h0010; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        wait_valid(n);
        chk("t2_latency", n, 8);
        chk("t2_instr_be", bus1.instr, 16'h3412);
        chk("t2_instr_le", bus0.instr, 16'h1234);
        step(); step();

        waits = 0;
        pc_addr = 16'h0023; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        chk("t3_mis", {bus0.misalign_err, bus1.misalign_err,
                       bus0.mem_rd, bus1.mem_rd}, 4'b1100);
        step(); step();
        flush = 1'b1; step(); flush = 1'b0;
        chk("t3_clr", {bus0.misalign_err, bus1.misalign_err}, 2'b00);

        en = 1'b0;
        pc_addr = 16'h0010; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        repeat (3) step();
        chk("t4_pre", {bus1.timeout_err, bus1.mem_rd}, 2'b01);
        step();
        chk("t4_to4", {bus1.timeout_err, bus1.mem_rd,
                       bus0.timeout_err, bus0.mem_rd}, 4'b1001);
        repeat (60) step();
        chk("t4_to64", {bus0.timeout_err, bus0.mem_rd}, 2'b10);
        frdy = 1'b1; en = 1'b1;
        repeat (3) step();
        frdy = 1'b0;
        chk("t4_sticky", {bus0.timeout_err, bus1.timeout_err,
                          bus0.instr_valid, bus1.instr_valid}, 4'b1100);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t4_clr", {bus0.timeout_err, bus1.timeout_err}, 2'b00);

        instr_ready = 1'b0; waits = 1;
        pc_addr = 16'h0010; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        wait_valid(n);
        chk("t5_latency", n, 4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold", {bus0.instr, bus0.instr_valid}, {16'h1234, 1'b1});
        end
        flush = 1'b1; instr_ready = 1'b1;
        step(); flush = 1'b0;
        chk("t5_flush", {bus0.instr_valid, bus0.pc_wre,
                         bus1.instr_valid, bus1.pc_wre}, 4'b0000);
        step();
        chk("t5_nowre", {bus0.pc_wre, bus1.pc_wre}, 2'b00);
        instr_ready = 1'b0;

        waits = 2;
        pc_addr = 16'h0010; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        repeat (3) step();
        RESET = 1'b0;
        #1;
        chk("t6_rst_u0", d_out[0], 37'h0);
        chk("t6_rst_u1", d_out[1], 37'h0);
        step(); RESET = 1'b1; step();
        waits = 0; instr_ready = 1'b1;
        pc_addr = 16'h0000; fetch_req = 1'b1;
        step(); fetch_req = 1'b0;
        repeat (2) step();
        chk("t6_instr_le", {bus0.instr, bus0.instr_valid}, {16'hABCD, 1'b1});
        chk("t6_instr_be", {bus1.instr, bus1.instr_valid}, {16'hCDAB, 1'b1});
        step(); step();

        pc_addr = 16'h0002; fetch_req = 1'b1;
        repeat (12) step();
        chk("b2b_instr", bus0.instr, 16'h5958);
        fetch_req = 1'b0;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end

endmodule
